// File: rtl/load_store_unit.sv
// Load/store unit between an RV32I core and a single-ported word memory.
// Sub-word stores are done as read-modify-write so the memory only needs full-word writes.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  // core side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // memory side
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;

  logic        rd_en, wr_en;
  logic [31:0] wr_word;
  logic        f3_legal, misaligned, out_of_range, dec_err;

  // Select the addressed byte/half (little-endian lanes) and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'h0, b};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic        half,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = word;
    if (half) begin
      if (off[1]) r[31:16] = wd;
      else        r[15:0]  = wd;
    end else begin
      r[{off, 3'b000} +: 8] = wd[7:0];
    end
    return r;
  endfunction

  // Request decode works straight off the core inputs so errors skip memory entirely.
  always_comb begin
    if (req_we) f3_legal = req_funct3 inside {F3_B, F3_H, F3_W};
    else        f3_legal = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS_W;
    dec_err      = !f3_legal || misaligned || out_of_range;
  end

  // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    merge_d  = merge_q;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    wr_word  = 32'h0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = dec_err;
          if (dec_err) begin
            rdata_d = 32'h0;
            state_d = RESP;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_funct3 == F3_W) begin
            state_d = STORE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        rd_en   = 1'b1;
        rdata_d = we_q ? 32'h0 : load_extend(mem_rdata, funct3_q, addr_q[1:0]);
        state_d = RESP;
      end
      STORE: begin
        wr_en   = 1'b1;
        wr_word = wdata_q;
        rdata_d = 32'h0;
        state_d = RESP;
      end
      RMW_RD: begin
        rd_en   = 1'b1;
        merge_d = store_merge(mem_rdata, wdata_q[15:0], funct3_q[0], addr_q[1:0]);
        state_d = RMW_WR;
      end
      RMW_WR: begin
        wr_en   = 1'b1;
        wr_word = merge_q;
        rdata_d = 32'h0;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      merge_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      merge_q  <= merge_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = rdata_q;

  // Strobes are gated by rst_n directly so a reset edge can never commit a write.
  assign mem_read  = rd_en && rst_n;
  assign mem_write = wr_en && rst_n;
  assign mem_wdata = mem_write ? wr_word : 32'h0;
  assign mem_addr  = (state_q == IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};

endmodule
